// File: rtl/sonar_sched_pkg.sv
// Shared types and constants for the sonar round-robin scheduler.
package sonar_sched_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSelect = 2'd1,
    StFire   = 2'd2,
    StWait   = 2'd3
  } sonar_state_e;

  localparam int unsigned DefaultSlotCycles = 3000000;
  localparam int unsigned DistW             = 8;

endpackage

// File: rtl/sonar_rr_pick.sv
// Combinational round-robin picker: next set mask bit after the current index,
// plus a flag telling whether the current index is the highest set mask bit.
module sonar_rr_pick #(
  parameter int unsigned NUM_SONARS = 4,
  parameter int unsigned IDX_W      = 2
) (
  input  logic [NUM_SONARS-1:0] i_mask,
  input  logic [IDX_W-1:0]      i_cur_idx,
  input  logic                  i_first,
  output logic [IDX_W-1:0]      o_next_idx,
  output logic                  o_is_last
);

  int unsigned           w_base;
  int unsigned           w_cand;
  logic [NUM_SONARS-1:0] w_sh;

  always_comb begin
    o_next_idx = i_cur_idx;
    w_cand     = 0;
    w_sh       = '0;
    // Starting from NUM_SONARS-1 makes the first candidate wrap to index 0.
    w_base     = i_first ? NUM_SONARS - 1 : 32'(i_cur_idx);
    for (int unsigned k = NUM_SONARS; k >= 1; k--) begin
      w_cand = (w_base + k) % NUM_SONARS;
      w_sh   = i_mask >> w_cand;
      if (w_sh[0]) begin
        o_next_idx = IDX_W'(w_cand);
      end
    end
    o_is_last = ((i_mask >> i_cur_idx) == NUM_SONARS'(1));
  end

endmodule

// File: rtl/sonar_sched.sv
// Round-robin scheduler firing one sr04 front-end per slot and capturing each
// sensor's distance, or a timeout, into per-sensor result registers.
module sonar_sched
  import sonar_sched_pkg::*;
#(
  parameter int unsigned NUM_SONARS  = 4,
  parameter int unsigned SLOT_CYCLES = DefaultSlotCycles,
  parameter int unsigned IDX_W       = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [NUM_SONARS-1:0]       mask,
  output logic [NUM_SONARS-1:0]       sr_en,
  output logic [NUM_SONARS-1:0]       sr_sync,
  input  logic [NUM_SONARS-1:0]       sr_valid,
  input  logic [DistW*NUM_SONARS-1:0] sr_dist,
  output logic [DistW*NUM_SONARS-1:0] dist_out,
  output logic [NUM_SONARS-1:0]       fresh,
  input  logic [NUM_SONARS-1:0]       fresh_clr,
  output logic [NUM_SONARS-1:0]       timeout,
  output logic [IDX_W-1:0]            active_idx,
  output logic                        cycle_done
);

  localparam int unsigned       CntW    = $clog2(SLOT_CYCLES);
  // Counter is 0 in FIRE, so SELECT + FIRE + WAIT repeat every SLOT_CYCLES clocks.
  localparam logic [CntW-1:0]   CntLast = CntW'(SLOT_CYCLES - 2);

  sonar_state_e                         r_state, w_state_d;
  logic [IDX_W-1:0]                     r_idx, w_next_idx;
  logic                                 r_first, r_captured, w_is_last;
  logic [CntW-1:0]                      r_cnt;
  logic [NUM_SONARS-1:0]                r_sr_en, r_fresh, r_timeout;
  logic [NUM_SONARS-1:0][DistW-1:0]     r_dist, w_sr_dist;
  logic [NUM_SONARS-1:0]                w_idx_oh, w_set;
  logic                                 w_any_mask, w_in_wait, w_slot_end;
  logic                                 w_valid_act, w_capture, w_expire;

  assign w_any_mask  = |mask;
  assign w_sr_dist   = sr_dist;
  assign w_idx_oh    = NUM_SONARS'(1) << r_idx;
  assign w_in_wait   = enable && (r_state == StWait);
  assign w_slot_end  = w_in_wait && (r_cnt == CntLast);
  assign w_valid_act = sr_valid[r_idx];
  assign w_capture   = w_in_wait && !r_captured && w_valid_act;
  assign w_expire    = w_slot_end && !r_captured && !w_valid_act;
  assign w_set       = (w_capture || w_expire) ? w_idx_oh : '0;

  sonar_rr_pick #(
    .NUM_SONARS (NUM_SONARS),
    .IDX_W      (IDX_W)
  ) u_rr_pick (
    .i_mask     (mask),
    .i_cur_idx  (r_idx),
    .i_first    (r_first),
    .o_next_idx (w_next_idx),
    .o_is_last  (w_is_last)
  );

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:   if (w_any_mask) w_state_d = StSelect;
      StSelect: w_state_d = w_any_mask ? StFire : StIdle;
      StFire:   w_state_d = StWait;
      StWait:   if (w_slot_end) w_state_d = w_any_mask ? StSelect : StIdle;
      default:  w_state_d = StIdle;
    endcase
    if (!enable) begin
      w_state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_idx      <= '0;
      r_first    <= 1'b1;
      r_captured <= 1'b0;
      r_cnt      <= '0;
      r_sr_en    <= '0;
    end else begin
      r_state <= w_state_d;
      r_sr_en <= {NUM_SONARS{enable}} & mask;
      if (w_state_d == StIdle) begin
        r_first <= 1'b1;
      end
      if (enable && (r_state == StSelect) && w_any_mask) begin
        r_idx   <= w_next_idx;
        r_first <= 1'b0;
      end
      if (r_state == StSelect) begin
        r_cnt <= '0;
      end else if (enable && ((r_state == StFire) || (r_state == StWait))) begin
        r_cnt <= r_cnt + CntW'(1);
      end
      if (enable && (r_state == StFire)) begin
        r_captured <= 1'b0;
      end else if (w_capture) begin
        r_captured <= 1'b1;
      end
    end
  end

  // Setting after clearing lets a capture win over a same-cycle fresh_clr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dist    <= '0;
      r_fresh   <= '0;
      r_timeout <= '0;
    end else begin
      r_fresh   <= (r_fresh & ~fresh_clr) | w_set;
      r_timeout <= (r_timeout & ~w_set) | (w_expire ? w_idx_oh : '0);
      if (w_capture) begin
        r_dist[r_idx] <= w_sr_dist[r_idx];
      end else if (w_expire) begin
        r_dist[r_idx] <= '0;
      end
    end
  end

  assign sr_en      = r_sr_en;
  assign sr_sync    = (enable && (r_state == StFire)) ? w_idx_oh : '0;
  assign dist_out   = r_dist;
  assign fresh      = r_fresh;
  assign timeout    = r_timeout;
  assign active_idx = r_idx;
  assign cycle_done = w_slot_end && w_is_last;

endmodule

// File: tb/tb_sonar_sched.sv
// Directed bench for sonar_sched with a short slot and simple sr04 echo models.
module tb_sonar_sched;

  logic        clk = 1'b0;
  logic        reset, enable, cycle_done;
  logic [3:0]  mask, sr_en, sr_sync, sr_valid, fresh, fresh_clr, timeout;
  logic [31:0] sr_dist, dist_out;
  logic [1:0]  active_idx;

  logic [3:0]  model_on, m_valid, man_valid;
  logic [7:0]  man_dist [4];
  int          m_cd [4];
  int          n_checks, n_errors, cyc, done_n, done_cyc, done_prev;
  int          sync_n [4];

  sonar_sched #(
    .NUM_SONARS  (4),
    .SLOT_CYCLES (100),
    .IDX_W       (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mask       (mask),
    .sr_en      (sr_en),
    .sr_sync    (sr_sync),
    .sr_valid   (sr_valid),
    .sr_dist    (sr_dist),
    .dist_out   (dist_out),
    .fresh      (fresh),
    .fresh_clr  (fresh_clr),
    .timeout    (timeout),
    .active_idx (active_idx),
    .cycle_done (cycle_done)
  );

  always #5 clk = ~clk;

  assign sr_valid = m_valid | man_valid;

  always_comb begin
    sr_dist = '0;
    for (int i = 0; i < 4; i++) begin
      sr_dist[8*i +: 8] = m_valid[i] ? 8'(8'h10 + i) : man_dist[i];
    end
  end

  // Echo model: one-cycle valid with dist 0x10+i a few cycles after sync.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      if (!reset) begin
        m_cd[i] = 0;
      end else begin
        if (m_cd[i] != 0) begin
          m_cd[i]--;
          if (m_cd[i] == 0) m_valid[i] = 1'b1;
        end
        if (sr_sync[i] && model_on[i]) m_cd[i] = 5;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (cycle_done) begin
      done_n++;
      done_prev = done_cyc;
      done_cyc  = cyc;
    end
    for (int i = 0; i < 4; i++) if (sr_sync[i]) sync_n[i]++;
  endtask

  task automatic wait_fire(input string tag, output int idx, output int at);
    idx = -1;
    at  = cyc;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (sr_sync != 4'b0) begin
        check({tag, "_onehot"}, $countones(sr_sync), 1);
        for (int i = 0; i < 4; i++) if (sr_sync[i]) idx = i;
        at = cyc;
        return;
      end
    end
    n_checks++;
    n_errors++;
    $display("FAIL %s: no sync within 300 cycles", tag);
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    enable    = 1'b0;
    mask      = 4'b0;
    man_valid = 4'b0;
    fresh_clr = 4'b0;
    repeat (6) tick();
    reset  = 1'b1;
    done_n = 0;
    for (int i = 0; i < 4; i++) sync_n[i] = 0;
    tick();
  endtask

  initial begin
    int idx, at, prev, e, s;
    n_checks = 0; n_errors = 0; cyc = 0; done_n = 0; done_cyc = 0; done_prev = 0;
    model_on = 4'b0;
    for (int i = 0; i < 4; i++) begin
      man_dist[i] = 8'h00;
      sync_n[i]   = 0;
    end

    // Full mask, every sensor echoes.
    do_reset();
    check("rst_sr_en", sr_en, 0);
    check("rst_sr_sync", sr_sync, 0);
    check("rst_dist", dist_out, 0);
    check("rst_fresh", fresh, 0);
    check("rst_timeout", timeout, 0);
    check("rst_idx", active_idx, 0);
    check("rst_done", cycle_done, 0);
    model_on = 4'hF; mask = 4'hF; enable = 1'b1; e = cyc;
    wait_fire("t1_f0", idx, at);
    check("t1_latency", at - e, 2);
    check("t1_idx0", idx, 0);
    prev = at;
    for (int k = 1; k <= 8; k++) begin
      wait_fire($sformatf("t1_f%0d", k), idx, at);
      check($sformatf("t1_idx%0d", k), idx, k % 4);
      check($sformatf("t1_gap%0d", k), at - prev, 100);
      prev = at;
      if (k == 4) begin
        check("t1_dist", dist_out, 32'h13121110);
        check("t1_fresh", fresh, 4'hF);
        check("t1_timeout", timeout, 0);
        check("t1_sr_en", sr_en, 4'hF);
        check("t1_done_n1", done_n, 1);
        check("t1_done_pos", at - done_cyc, 2);
      end
    end
    check("t1_done_n2", done_n, 2);
    check("t1_done_gap", done_cyc - done_prev, 400);

    // Sparse mask, sensor 2 silent.
    do_reset();
    model_on = 4'b1011; mask = 4'b0101; enable = 1'b1;
    wait_fire("t2_f0", idx, prev);
    check("t2_idx0", idx, 0);
    wait_fire("t2_f1", idx, at);
    check("t2_idx1", idx, 2);
    check("t2_gap1", at - prev, 100);
    prev = at;
    wait_fire("t2_f2", idx, at);
    check("t2_idx2", idx, 0);
    check("t2_gap2", at - prev, 100);
    check("t2_timeout", timeout, 4'b0100);
    check("t2_dist", dist_out, 32'h0000_0010);
    check("t2_fresh", fresh, 4'b0101);
    check("t2_unmasked", sync_n[1] + sync_n[3], 0);

    // Valid on the last WAIT cycle, colliding with fresh_clr.
    do_reset();
    model_on = 4'b0; mask = 4'b0010; enable = 1'b1;
    wait_fire("t3_f0", idx, prev);
    check("t3_idx0", idx, 1);
    repeat (97) tick();
    check("t3_done_early", cycle_done, 0);
    tick();
    check("t3_done_last", cycle_done, 1);
    check("t3_fresh_pre", fresh, 0);
    man_valid = 4'b0010; man_dist[1] = 8'hAA; fresh_clr = 4'b0010;
    tick();
    man_valid = 4'b0; fresh_clr = 4'b0;
    check("t3_dist_aa", dist_out[15:8], 8'hAA);
    check("t3_timeout", timeout, 0);
    check("t3_fresh_win", fresh, 4'b0010);
    wait_fire("t3_f1", idx, at);
    check("t3_idx1", idx, 1);
    check("t3_gap", at - prev, 100);
    repeat (3) tick();
    man_valid = 4'b0010; man_dist[1] = 8'h33;
    tick();
    man_dist[1] = 8'h44;
    tick();
    man_valid = 4'b0;
    tick();
    check("t3_first_only", dist_out[15:8], 8'h33);
    fresh_clr = 4'b0010;
    tick();
    fresh_clr = 4'b0;
    check("t3_fresh_clr", fresh, 0);

    // Valid from a non-active sensor.
    do_reset();
    model_on = 4'b0; mask = 4'b1001; enable = 1'b1;
    wait_fire("t4_f0", idx, at);
    check("t4_idx0", idx, 0);
    tick();
    check("t4_active", active_idx, 0);
    man_valid = 4'b1000; man_dist[3] = 8'h55;
    tick();
    man_valid = 4'b0;
    check("t4_dist", dist_out, 0);
    check("t4_fresh", fresh, 0);

    // Enable drop mid-WAIT, re-enable, asynchronous reset.
    do_reset();
    model_on = 4'hF; mask = 4'hF; enable = 1'b1;
    wait_fire("t5_f0", idx, at);
    wait_fire("t5_f1", idx, at);
    wait_fire("t5_f2", idx, at);
    check("t5_idx2", idx, 2);
    repeat (2) tick();
    enable = 1'b0;
    tick();
    check("t5_sync_off", sr_sync, 0);
    check("t5_idx_kept", active_idx, 2);
    s = sync_n[0] + sync_n[1] + sync_n[2] + sync_n[3];
    repeat (150) tick();
    check("t5_no_fire", sync_n[0] + sync_n[1] + sync_n[2] + sync_n[3], s);
    check("t5_dist_kept", dist_out, 32'h0000_1110);
    check("t5_fresh_kept", fresh, 4'b0011);
    check("t5_sr_en_off", sr_en, 0);
    enable = 1'b1; e = cyc;
    wait_fire("t5_re", idx, at);
    check("t5_re_idx", idx, 0);
    check("t5_re_latency", at - e, 2);
    repeat (10) tick();
    check("t5_sr_en_on", sr_en, 4'hF);
    reset = 1'b0;
    #1;
    check("t5_arst_sr_en", sr_en, 0);
    check("t5_arst_dist", dist_out, 0);
    check("t5_arst_fresh", fresh, 0);
    check("t5_arst_timeout", timeout, 0);
    check("t5_arst_idx", active_idx, 0);
    check("t5_arst_sync", sr_sync, 0);
    check("t5_arst_done", cycle_done, 0);
    tick();
    reset = 1'b1;

    // Mask shrinks to a single sensor during sensor 0's slot.
    do_reset();
    model_on = 4'hF; mask = 4'hF; enable = 1'b1;
    wait_fire("t6_f0", idx, prev);
    check("t6_idx0", idx, 0);
    repeat (10) tick();
    mask = 4'b0010;
    for (int k = 1; k <= 3; k++) begin
      wait_fire($sformatf("t6_f%0d", k), idx, at);
      check($sformatf("t6_idx%0d", k), idx, 1);
      check($sformatf("t6_gap%0d", k), at - prev, 100);
      if (k == 1) check("t6_no_done_slot0", done_n, 0);
      prev = at;
    end
    check("t6_done_n", done_n, 2);
    check("t6_done_pos", at - done_cyc, 2);
    check("t6_dist", dist_out, 32'h0000_1110);
    check("t6_unmasked", sync_n[2] + sync_n[3], 0);
    check("t6_sr_en", sr_en, 4'b0010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
